irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Fast interrupt controller that sits directly upstream of the five-stage MCU core.
- Synchronises external interrupt lines and latches rising edges as pending.
- Masks and arbitrates pending sources by fixed priority, then presents one request with its ID and vector address to the core.
- Tracks the request through core acknowledge (redirect taken in ID) and completion (mret retired). Single level: no nesting.

Parameters:
NUM_IRQ, 16, number of interrupt sources (2..32)
ID_W, $clog2(NUM_IRQ), width of interrupt ID
VEC_BASE, 32'h0000_0100, vector table base; vector = VEC_BASE + (id << 2)

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset; clears all state
irq_src_i  input  NUM_IRQ  raw asynchronous interrupt lines, edge-triggered
global_en_i  input  1  global interrupt enable (mstatus.MIE) from core
en_wr_i  input  1  write strobe for enable mask
en_data_i  input  NUM_IRQ  new enable mask value
irq_ack_i  input  1  core accepted request; redirect to vector taken this cycle
irq_done_i  input  1  handler finished (mret retired)
irq_req_o  output  1  interrupt request to core
irq_id_o  output  ID_W  ID of requested/in-service interrupt
irq_vector_o  output  32  handler address for irq_id_o
irq_busy_o  output  1  handler in service
pending_o  output  NUM_IRQ  pending register (debug/CSR readback)
en_mask_o  output  NUM_IRQ  current enable mask

Behaviour:
- Reset: sync flops, previous-sample flops, pending, en_mask, req, busy and id all 0; state IDLE; irq_vector_o = VEC_BASE.
- Synchroniser: two-flop chain per line (s1, s2), plus a prev flop holding the last s2.
- Edge: rise = s2 & ~prev. Pending bit i is set on the edge after rise[i] is seen.
- Latency: line rises before edge k → s2 at k+1 → pending at k+2 → irq_req_o high after edge k+3.
- Enable mask: en_wr_i loads en_data_i at the clock edge. Masked sources still latch pending; they become eligible as soon as they are enabled.
- Arbitration: candidate = lowest index i with pending[i] & en_mask[i]. Purely combinational on registered state.
- FSM states:
  - IDLE: irq_req_o=0, irq_busy_o=0. If global_en_i and any candidate, latch candidate ID into id register → REQ.
  - REQ: irq_req_o=1. irq_id_o/irq_vector_o are held stable, even if a higher-priority source becomes pending.
    - irq_ack_i → clear pending[id], go to SERVICE.
    - Else if global_en_i=0 → withdraw to IDLE (irq_req_o low next cycle; pending unchanged).
    - irq_ack_i has priority over a global_en_i drop in the same cycle.
  - SERVICE: irq_req_o=0, irq_busy_o=1, irq_id_o holds the serviced ID. irq_done_i → IDLE.
- Re-arbitration: no request is issued in the cycle after leaving SERVICE, so there is at least one idle cycle between handlers.
- irq_ack_i in IDLE/SERVICE and irq_done_i in IDLE/REQ are ignored.
- Same-cycle set and clear of one pending bit (new edge on the acked ID): set wins, so the bit stays 1.
- A source re-edging while already pending merges into the single pending bit.
- Vector arithmetic: 32-bit, VEC_BASE + {id, 2'b00}, zero-extended, wraps modulo 2^32.
- Reset asserted mid-REQ/SERVICE: immediately returns to reset values; pending interrupts are lost.
- Outputs irq_req_o, irq_busy_o and irq_id_o are registered. irq_vector_o is derived from the registered id only.

Test Plan:
- Reset release, enable mask 16'h0004, pulse irq_src_i[2] at edge 0 → irq_req_o=1 after edge 3, irq_id_o=2, irq_vector_o=32'h0000_0108.
- Sources 5 and 3 both pending, both enabled → id=3 first. Ack → busy=1, pending=16'h0020. Done → one idle cycle, then req with id=5 and vector 32'h0000_0114.
- Source 7 pending, mask 0 → no req. Write mask 16'h0080 → req rises the following cycle with id=7.
- In REQ with id=4, drop global_en_i → req=0 next cycle and pending[4] still 1. Restore global_en_i → req reasserts with id=4.
- In REQ, a new edge on the same source arrives the cycle ack is asserted → state SERVICE, pending bit remains 1. After done, source re-requests.
- Assert reset during SERVICE → immediately req=0, busy=0, pending=0, mask=0, vector=VEC_BASE. Stray irq_ack_i/irq_done_i while IDLE → no state change.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// Bundle of the irq_ctrl bus signals: interrupt lines, mask CSR write and core handshake.
// slave = controller side, master = core/CSR side.
interface irq_ctrl_if #(
  parameter int unsigned NUM_IRQ = 16,
  parameter int unsigned ID_W    = $clog2(NUM_IRQ)
);
  logic [NUM_IRQ-1:0] irq_src_i;
  logic               global_en_i;
  logic               en_wr_i;
  logic [NUM_IRQ-1:0] en_data_i;
  logic               irq_ack_i;
  logic               irq_done_i;
  logic               irq_req_o;
  logic [ID_W-1:0]    irq_id_o;
  logic [31:0]        irq_vector_o;
  logic               irq_busy_o;
  logic [NUM_IRQ-1:0] pending_o;
  logic [NUM_IRQ-1:0] en_mask_o;

  modport slave (
    input  irq_src_i, global_en_i, en_wr_i, en_data_i, irq_ack_i, irq_done_i,
    output irq_req_o, irq_id_o, irq_vector_o, irq_busy_o, pending_o, en_mask_o
  );

  modport master (
    output irq_src_i, global_en_i, en_wr_i, en_data_i, irq_ack_i, irq_done_i,
    input  irq_req_o, irq_id_o, irq_vector_o, irq_busy_o, pending_o, en_mask_o
  );
endinterface

// File: rtl/irq_ctrl.sv
// Single-level fast interrupt controller: synchronises and edge-detects lines, latches
// pending bits, arbitrates by fixed priority (lowest index wins) and tracks req/ack/done.
module irq_ctrl #(
  parameter int unsigned NUM_IRQ  = 16,
  parameter int unsigned ID_W     = $clog2(NUM_IRQ),
  parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
  input logic       clk,
  input logic       reset,
  irq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] s1_q, s2_q, prev_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d, mask_q, mask_d;
  logic [NUM_IRQ-1:0] rise, cand, clr;
  logic [ID_W-1:0]    id_q, id_d, cand_id;
  logic               cand_vld;
  logic               req_q, req_d, busy_q, busy_d;

  assign rise = s2_q & ~prev_q;
  assign cand = pend_q & mask_q;

  always_comb begin
    cand_vld = 1'b0;
    cand_id  = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (!cand_vld && cand[i]) begin
        cand_vld = 1'b1;
        cand_id  = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.global_en_i && cand_vld) begin
          id_d    = cand_id;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // ack outranks a same-cycle global enable drop
        if (bus.irq_ack_i) begin
          clr[id_q] = 1'b1;
          state_d   = S_SERVICE;
        end else if (!bus.global_en_i) begin
          state_d = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (bus.irq_done_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    req_d  = (state_d == S_REQ);
    busy_d = (state_d == S_SERVICE);
    // a fresh edge on the acked source survives the clear
    pend_d = (pend_q & ~clr) | rise;
    mask_d = bus.en_wr_i ? bus.en_data_i : mask_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      id_q    <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= bus.irq_src_i;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.irq_req_o    = req_q;
  assign bus.irq_busy_o   = busy_q;
  assign bus.irq_id_o     = id_q;
  assign bus.irq_vector_o = VEC_BASE + (32'(id_q) << 2);
  assign bus.pending_o    = pend_q;
  assign bus.en_mask_o    = mask_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a per-cycle vector table plus hand-written corner sequences.
module tb_irq_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  irq_ctrl_if #(.NUM_IRQ(16), .ID_W(4)) bus ();

  irq_ctrl #(.NUM_IRQ(16), .ID_W(4), .VEC_BASE(32'h0000_0100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] src;
    logic        gen, wr;
    logic [15:0] data;
    logic        ack, done;
    logic        req, busy;
    logic [3:0]  id;
    logic [15:0] pend, mask;
    logic [31:0] vec;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic [15:0] src, input logic gen, input logic wr,
                              input logic [15:0] data, input logic ack, input logic done,
                              input logic req, input logic busy, input logic [3:0] id,
                              input logic [15:0] pend, input logic [15:0] mask,
                              input logic [31:0] vec);
    vec_t r;
    r.src = src; r.gen = gen; r.wr = wr; r.data = data; r.ack = ack; r.done = done;
    r.req = req; r.busy = busy; r.id = id; r.pend = pend; r.mask = mask; r.vec = vec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req, input logic busy,
                         input logic [3:0] id, input logic [15:0] pend,
                         input logic [15:0] mask, input logic [31:0] vec);
    chk({tag, ".req"},  32'(bus.irq_req_o),  32'(req));
    chk({tag, ".busy"}, 32'(bus.irq_busy_o), 32'(busy));
    chk({tag, ".id"},   32'(bus.irq_id_o),   32'(id));
    chk({tag, ".pend"}, 32'(bus.pending_o),  32'(pend));
    chk({tag, ".mask"}, 32'(bus.en_mask_o),  32'(mask));
    chk({tag, ".vec"},  bus.irq_vector_o,    vec);
  endtask

  // drive one cycle of inputs, clock it, and leave the bench 1 time unit past the edge
  task automatic cyc(input logic [15:0] src, input logic gen, input logic wr,
                     input logic [15:0] data, input logic ack, input logic done);
    bus.irq_src_i   = src;
    bus.global_en_i = gen;
    bus.en_wr_i     = wr;
    bus.en_data_i   = data;
    bus.irq_ack_i   = ack;
    bus.irq_done_i  = done;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    bus.irq_src_i   = '0;
    bus.global_en_i = 1'b1;
    bus.en_wr_i     = 1'b0;
    bus.en_data_i   = '0;
    bus.irq_ack_i   = 1'b0;
    bus.irq_done_i  = 1'b0;

    //            src    gen wr data    ack done  req busy id pend     mask     vec
    tbl[0]  = mk(16'h0, 1, 1, 16'h0004, 0, 0,   0, 0, 0, 16'h0000, 16'h0004, 32'h100);
    tbl[1]  = mk(16'h4, 1, 0, 16'h0000, 0, 0,   0, 0, 0, 16'h0000, 16'h0004, 32'h100);
    tbl[2]  = mk(16'h0, 1, 0, 16'h0000, 0, 0,   0, 0, 0, 16'h0000, 16'h0004, 32'h100);
    tbl[3]  = mk(16'h0, 1, 0, 16'h0000, 0, 0,   0, 0, 0, 16'h0004, 16'h0004, 32'h100);
    tbl[4]  = mk(16'h0, 1, 0, 16'h0000, 0, 0,   1, 0, 2, 16'h0004, 16'h0004, 32'h108);
    tbl[5]  = mk(16'h0, 1, 0, 16'h0000, 1, 0,   0, 1, 2, 16'h0000, 16'h0004, 32'h108);
    tbl[6]  = mk(16'h0, 1, 0, 16'h0000, 0, 1,   0, 0, 2, 16'h0000, 16'h0004, 32'h108);
    tbl[7]  = mk(16'h0, 1, 1, 16'h0000, 0, 0,   0, 0, 2, 16'h0000, 16'h0000, 32'h108);
    tbl[8]  = mk(16'h80,1, 0, 16'h0000, 0, 0,   0, 0, 2, 16'h0000, 16'h0000, 32'h108);
    tbl[9]  = mk(16'h0, 1, 0, 16'h0000, 0, 0,   0, 0, 2, 16'h0000, 16'h0000, 32'h108);
    tbl[10] = mk(16'h0, 1, 0, 16'h0000, 0, 0,   0, 0, 2, 16'h0080, 16'h0000, 32'h108);
    tbl[11] = mk(16'h0, 1, 0, 16'h0000, 0, 0,   0, 0, 2, 16'h0080, 16'h0000, 32'h108);
    tbl[12] = mk(16'h0, 1, 1, 16'h0080, 0, 0,   0, 0, 2, 16'h0080, 16'h0080, 32'h108);
    tbl[13] = mk(16'h0, 1, 0, 16'h0000, 0, 0,   1, 0, 7, 16'h0080, 16'h0080, 32'h11C);
    tbl[14] = mk(16'h0, 1, 0, 16'h0000, 1, 0,   0, 1, 7, 16'h0000, 16'h0080, 32'h11C);
    tbl[15] = mk(16'h0, 1, 0, 16'h0000, 0, 1,   0, 0, 7, 16'h0000, 16'h0080, 32'h11C);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_all("reset", 0, 0, 0, 16'h0000, 16'h0000, 32'h100);

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].src, tbl[i].gen, tbl[i].wr, tbl[i].data, tbl[i].ack, tbl[i].done);
      chk_all($sformatf("row%0d", i), tbl[i].req, tbl[i].busy, tbl[i].id,
              tbl[i].pend, tbl[i].mask, tbl[i].vec);
    end

    // priority: sources 5 and 3 pending together
    cyc(16'h0000, 1, 1, 16'h0028, 0, 0);
    cyc(16'h0028, 1, 0, 16'h0000, 0, 0);
    cyc(16'h0000, 1, 0, 16'h0000, 0, 0);
    cyc(16'h0000, 1, 0, 16'h0000, 0, 0);
    chk_all("prio.pend", 0, 0, 7, 16'h0028, 16'h0028, 32'h11C);
    cyc(16'h0000, 1, 0, 16'h0000, 0, 0);
    chk_all("prio.req3", 1, 0, 3, 16'h0028, 16'h0028, 32'h10C);
    cyc(16'h0000, 1, 0, 16'h0000, 1, 0);
    chk_all("prio.ack3", 0, 1, 3, 16'h0020, 16'h0028, 32'h10C);
    cyc(16'h0000, 1, 0, 16'h0000, 0, 1);
    chk_all("prio.gap", 0, 0, 3, 16'h0020, 16'h0028, 32'h10C);
    cyc(16'h0000, 1, 0, 16'h0000, 0, 0);
    chk_all("prio.req5", 1, 0, 5, 16'h0020, 16'h0028, 32'h114);
    cyc(16'h0000, 1, 0, 16'h0000, 1, 0);
    cyc(16'h0000, 1, 0, 16'h0000, 0, 1);
    chk_all("prio.end", 0, 0, 5, 16'h0000, 16'h0028, 32'h114);

    // global enable withdrawal while requesting id 4
    cyc(16'h0000, 1, 1, 16'h0010, 0, 0);
    cyc(16'h0010, 1, 0, 16'h0000, 0, 0);
    cyc(16'h0000, 1, 0, 16'h0000, 0, 0);
    cyc(16'h0000, 1, 0, 16'h0000, 0, 0);
    cyc(16'h0000, 1, 0, 16'h0000, 0, 0);
    chk_all("gen.req4", 1, 0, 4, 16'h0010, 16'h0010, 32'h110);
    cyc(16'h0000, 0, 0, 16'h0000, 0, 0);
    chk_all("gen.drop", 0, 0, 4, 16'h0010, 16'h0010, 32'h110);
    cyc(16'h0000, 0, 0, 16'h0000, 0, 0);
    chk_all("gen.held", 0, 0, 4, 16'h0010, 16'h0010, 32'h110);
    cyc(16'h0000, 1, 0, 16'h0000, 0, 0);
    chk_all("gen.back", 1, 0, 4, 16'h0010, 16'h0010, 32'h110);

    // new edge on source 4 lands in the same cycle as its ack
    cyc(16'h0010, 1, 0, 16'h0000, 0, 0);
    cyc(16'h0000, 1, 0, 16'h0000, 0, 0);
    chk_all("setclr.pre", 1, 0, 4, 16'h0010, 16'h0010, 32'h110);
    cyc(16'h0000, 1, 0, 16'h0000, 1, 0);
    chk_all("setclr.ack", 0, 1, 4, 16'h0010, 16'h0010, 32'h110);
    cyc(16'h0000, 1, 0, 16'h0000, 0, 1);
    chk_all("setclr.gap", 0, 0, 4, 16'h0010, 16'h0010, 32'h110);
    cyc(16'h0000, 1, 0, 16'h0000, 0, 0);
    chk_all("setclr.rereq", 1, 0, 4, 16'h0010, 16'h0010, 32'h110);
    cyc(16'h0000, 1, 0, 16'h0000, 1, 0);
    chk_all("setclr.svc", 0, 1, 4, 16'h0000, 16'h0010, 32'h110);

    // masked source 0 goes pending while in service, then async reset
    cyc(16'h0001, 1, 0, 16'h0000, 0, 0);
    cyc(16'h0000, 1, 0, 16'h0000, 0, 0);
    cyc(16'h0000, 1, 0, 16'h0000, 0, 0);
    chk_all("rst.pre", 0, 1, 4, 16'h0001, 16'h0010, 32'h110);
    #2 reset = 1'b1;
    #1;
    chk_all("rst.async", 0, 0, 0, 16'h0000, 16'h0000, 32'h100);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(16'h0000, 1, 0, 16'h0000, 1, 0);
    chk_all("stray.ack", 0, 0, 0, 16'h0000, 16'h0000, 32'h100);
    cyc(16'h0000, 1, 0, 16'h0000, 0, 1);
    chk_all("stray.done", 0, 0, 0, 16'h0000, 16'h0000, 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
